// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph constants (active-low, seg[0]=a .. seg[6]=g)
// and the glyph classification used by the encoders and this receiver.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      GLYPH_HEX   = 2'd0,
      GLYPH_BLANK = 2'd1,
      GLYPH_ERR   = 2'd2
   } glyph_class_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: raw active-low segment pattern to class and hex value.
// Blank and illegal patterns report value 0.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0]   pattern,
   output glyph_class_t glyph_class,
   output logic [3:0]   value
);

   always_comb begin
      glyph_class = GLYPH_HEX;
      value       = 4'h0;
      case (pattern)
         SEG_0:     value = 4'h0;
         SEG_1:     value = 4'h1;
         SEG_2:     value = 4'h2;
         SEG_3:     value = 4'h3;
         SEG_4:     value = 4'h4;
         SEG_5:     value = 4'h5;
         SEG_6:     value = 4'h6;
         SEG_7:     value = 4'h7;
         SEG_8:     value = 4'h8;
         SEG_9:     value = 4'h9;
         SEG_A:     value = 4'hA;
         SEG_B:     value = 4'hB;
         SEG_C:     value = 4'hC;
         SEG_D:     value = 4'hD;
         SEG_E:     value = 4'hE;
         SEG_F:     value = 4'hF;
         SEG_BLANK: glyph_class = GLYPH_BLANK;
         default:   glyph_class = GLYPH_ERR;
      endcase
   end

endmodule

// File: rtl/seg7_scan_rx.sv
// Multiplexed seven-segment bus receiver: qualifies each digit's pattern over
// STABLE_CYCLES samples, keeps a decoded per-digit table and emits change events.
module seg7_scan_rx
   import seg7_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DIGITS-1:0]          an,
   input  logic [6:0]                 seg,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DIGITS)-1:0]  out_digit,
   output logic [3:0]                 out_value,
   output logic                       out_blank,
   output logic                       out_error,
   output logic [4*DIGITS-1:0]        digit_values,
   output logic [DIGITS-1:0]          digit_known,
   output logic                       overrun
);

   localparam int         DW       = $clog2(DIGITS);
   localparam logic [3:0] TMR_LOAD = 4'(STABLE_CYCLES - 1);

   logic [DIGITS-1:0] an_q;
   logic [6:0]        seg_q;

   logic              sel_valid;
   logic [DW-1:0]     sel_idx;

   logic              trk_valid;
   logic [DW-1:0]     trk_idx;
   logic [6:0]        trk_seg;
   logic [3:0]        tmr;

   logic [6:0]        last_raw [DIGITS];
   logic [DIGITS-1:0] seen;

   glyph_class_t      cls;
   logic [3:0]        val;
   logic              same;
   logic              accept;
   logic              new_evt;
   logic              can_load;

   seg7_glyph_decode u_decode (
      .pattern     (seg_q),
      .glyph_class (cls),
      .value       (val)
   );

   always_comb begin
      sel_valid = $onehot(~an_q);
      sel_idx   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!an_q[i]) sel_idx = DW'(i);
      end
   end

   // tmr is a down-counter of samples still needed; reaching 1 on a matching
   // sample means this edge completes STABLE_CYCLES identical samples.
   always_comb begin
      same     = trk_valid && (trk_idx == sel_idx) && (trk_seg == seg_q);
      accept   = sel_valid && same && (tmr == 4'd1);
      new_evt  = accept && (!seen[sel_idx] || (last_raw[sel_idx] != seg_q));
      can_load = !out_valid || out_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an_q         <= '1;
         seg_q        <= SEG_BLANK;
         trk_valid    <= 1'b0;
         trk_idx      <= '0;
         trk_seg      <= '0;
         tmr          <= '0;
         seen         <= '0;
         for (int i = 0; i < DIGITS; i++) last_raw[i] <= '0;
         digit_values <= '0;
         digit_known  <= '0;
         out_valid    <= 1'b0;
         out_digit    <= '0;
         out_value    <= '0;
         out_blank    <= 1'b0;
         out_error    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         an_q  <= an;
         seg_q <= seg;

         if (!sel_valid) begin
            trk_valid <= 1'b0;
            tmr       <= '0;
         end else begin
            trk_valid <= 1'b1;
            trk_idx   <= sel_idx;
            trk_seg   <= seg_q;
            if (!same)           tmr <= TMR_LOAD;
            else if (tmr != '0)  tmr <= tmr - 4'd1;
         end

         if (new_evt) begin
            seen[sel_idx]     <= 1'b1;
            last_raw[sel_idx] <= seg_q;
            digit_values[{sel_idx, 2'b00} +: 4] <= (cls == GLYPH_HEX) ? val : 4'h0;
            digit_known[sel_idx]                <= (cls == GLYPH_HEX);
         end

         if (new_evt && can_load) begin
            out_valid <= 1'b1;
            out_digit <= sel_idx;
            out_value <= val;
            out_blank <= (cls == GLYPH_BLANK);
            out_error <= (cls == GLYPH_ERR);
         end else if (new_evt) begin
            overrun <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed bench for seg7_scan_rx (DIGITS=4, STABLE_CYCLES=3) with hand-computed expectations.
module tb_seg7_scan_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_digit;
   logic [3:0]  out_value;
   logic        out_blank;
   logic        out_error;
   logic [15:0] digit_values;
   logic [3:0]  digit_known;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   seg7_scan_rx #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .an           (an),
      .seg          (seg),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_digit    (out_digit),
      .out_value    (out_value),
      .out_blank    (out_blank),
      .out_error    (out_error),
      .digit_values (digit_values),
      .digit_known  (digit_known),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] scan_an  [4];
   logic [6:0] scan_seg [4];
   int         n;

   initial begin
      scan_an[0] = 4'b1110; scan_seg[0] = 7'h08;
      scan_an[1] = 4'b1101; scan_seg[1] = 7'h03;
      scan_an[2] = 4'b1011; scan_seg[2] = 7'h46;
      scan_an[3] = 4'b0111; scan_seg[3] = 7'h21;

      reset = 1'b1; an = 4'hF; seg = 7'h7F; out_ready = 1'b1;
      tick(2);
      check("rst_valid",   32'(out_valid),    32'h0);
      check("rst_digit",   32'(out_digit),    32'h0);
      check("rst_value",   32'(out_value),    32'h0);
      check("rst_blank",   32'(out_blank),    32'h0);
      check("rst_error",   32'(out_error),    32'h0);
      check("rst_values",  32'(digit_values), 32'h0);
      check("rst_known",   32'(digit_known),  32'h0);
      check("rst_overrun", 32'(overrun),      32'h0);
      reset = 1'b0;

      // single digit 2 showing '3'
      an = 4'b1011; seg = 7'h30;
      tick(3);
      check("d2_early", 32'(out_valid), 32'h0);
      tick(1);
      check("d2_valid",  32'(out_valid),    32'h1);
      check("d2_digit",  32'(out_digit),    32'h2);
      check("d2_value",  32'(out_value),    32'h3);
      check("d2_flags",  32'({out_blank, out_error}), 32'h0);
      check("d2_known",  32'(digit_known),  32'h4);
      check("d2_values", 32'(digit_values), 32'h0300);
      tick(1);
      check("d2_drained", 32'(out_valid), 32'h0);
      tick(6);
      check("d2_norepeat", 32'(out_valid), 32'h0);

      // scan A,B,C,D across digits 0..3
      for (int d = 0; d < 4; d++) begin
         an = scan_an[d]; seg = scan_seg[d];
         tick(4);
         check("scan_valid", 32'(out_valid), 32'h1);
         check("scan_digit", 32'(out_digit), 32'(d));
         check("scan_value", 32'(out_value), 32'(4'hA + 4'(d)));
      end
      check("scan_values", 32'(digit_values), 32'hDCBA);
      check("scan_known",  32'(digit_known),  32'hF);

      // blank then illegal on digit 0
      an = 4'b1110; seg = 7'h7F;
      tick(4);
      check("blank_valid", 32'(out_valid), 32'h1);
      check("blank_digit", 32'(out_digit), 32'h0);
      check("blank_flags", 32'({out_blank, out_error, out_value}), 32'h20);
      seg = 7'h55;
      tick(4);
      check("err_valid",  32'(out_valid), 32'h1);
      check("err_flags",  32'({out_blank, out_error, out_value}), 32'h10);
      check("err_known",  32'(digit_known),  32'hE);
      check("err_values", 32'(digit_values), 32'hDCB0);
      tick(1);
      check("err_drained", 32'(out_valid), 32'h0);

      // invalid selects and unstable patterns: nothing may load
      out_ready = 1'b0;
      an = 4'b0011; seg = 7'h19;
      tick(6);
      check("two_low_noevt", 32'(out_valid), 32'h0);
      an = 4'b1111;
      tick(6);
      check("none_low_noevt", 32'(out_valid), 32'h0);
      an = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         seg = 7'h12; tick(2);
         seg = 7'h02; tick(2);
      end
      check("toggle_noevt",  32'(out_valid),    32'h0);
      check("toggle_values", 32'(digit_values), 32'hDCB0);
      check("toggle_known",  32'(digit_known),  32'hE);
      an = 4'b1111;
      tick(2);

      // back-pressure: first event held, second dropped
      an = 4'b1110; seg = 7'h40;
      tick(4);
      check("bp1_valid",   32'(out_valid), 32'h1);
      check("bp1_digit",   32'(out_digit), 32'h0);
      check("bp1_overrun", 32'(overrun),   32'h0);
      an = 4'b0111; seg = 7'h79;
      tick(4);
      check("bp2_valid",   32'(out_valid), 32'h1);
      check("bp2_digit",   32'(out_digit), 32'h0);
      check("bp2_value",   32'(out_value), 32'h0);
      check("bp2_overrun", 32'(overrun),   32'h1);
      check("bp2_values",  32'(digit_values), 32'h1CB0);
      check("bp2_known",   32'(digit_known),  32'hF);

      // reset while an event is pending, input left unchanged
      reset = 1'b1;
      tick(1);
      check("mrst_valid",   32'(out_valid),    32'h0);
      check("mrst_values",  32'(digit_values), 32'h0);
      check("mrst_known",   32'(digit_known),  32'h0);
      check("mrst_overrun", 32'(overrun),      32'h0);
      check("mrst_payload", 32'({out_digit, out_value, out_blank, out_error}), 32'h0);
      reset = 1'b0; out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 10) begin
         tick(1);
         n++;
      end
      check("regen_valid", 32'(out_valid),   32'h1);
      check("regen_digit", 32'(out_digit),   32'h3);
      check("regen_value", 32'(out_value),   32'h1);
      check("regen_known", 32'(digit_known), 32'h8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
